// File: rtl/sync_pkg.sv
// Shared types and default constants for the lockstep retire synchroniser.
// Imported by the per-core channel and by the group-level top.
package sync_pkg;

  typedef enum logic [1:0] {
    CH_RUN  = 2'b00,
    CH_HOLD = 2'b01,
    CH_DONE = 2'b10
  } ch_state_e;

  localparam int SYNC_MAX_WAIT = 64;
  localparam int SYNC_CNT_W    = 32;

endpackage

// File: rtl/sync_channel.sv
// One lockstep channel: parks a core after each fresh retire or a halt,
// and gates that core's clock enable until the group releases it.
module sync_channel
  import sync_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      retire_i,
  input  logic      halt_i,
  input  logic      release_i,
  input  logic      desync_i,
  output ch_state_e state_o,
  output logic      clk_en_o
);

  ch_state_e r_state;
  ch_state_e w_stateNext;
  logic      r_fresh;
  logic      w_hit;

  // A held RVFI valid only counts if the core was clocked last cycle.
  assign w_hit    = retire_i & r_fresh;
  assign clk_en_o = (r_state == CH_RUN) & ~w_hit & ~halt_i & ~desync_i;
  assign state_o  = r_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= CH_RUN;
      r_fresh <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_fresh <= clk_en_o;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (!desync_i) begin
      case (r_state)
        CH_RUN: begin
          if (w_hit) begin
            w_stateNext = CH_HOLD;
          end else if (halt_i) begin
            w_stateNext = CH_DONE;
          end
        end
        CH_HOLD: begin
          if (release_i) begin
            w_stateNext = CH_RUN;
          end
        end
        default: w_stateNext = r_state;
      endcase
    end
  end

endmodule

// File: rtl/multi_clk_sync.sv
// Lockstep synchroniser for NUM_CORES cores: releases a retire group once every
// live core has parked, and flags halts, mismatches and stalled groups.
module multi_clk_sync
  import sync_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  parameter  int MAX_WAIT  = SYNC_MAX_WAIT,
  localparam int CNT_W     = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_CORES-1:0]  retire_i,
  input  logic [NUM_CORES-1:0]  halt_i,
  output logic [NUM_CORES-1:0]  clk_en_o,
  output logic                  retire_o,
  output logic [SYNC_CNT_W-1:0] retire_cnt_o,
  output logic                  desync_o,
  output logic                  finished_o
);

  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  ch_state_e             w_state [NUM_CORES];
  logic                  w_allParked;
  logic                  w_anyHold;
  logic                  w_anyDone;
  logic                  w_allDone;
  logic                  w_release;
  logic                  w_mismatch;
  logic                  w_timeout;
  logic [CNT_W-1:0]      w_waitInc;
  logic [CNT_W-1:0]      r_waitCnt;
  logic [SYNC_CNT_W-1:0] r_retireCnt;
  logic                  r_desync;
  logic                  r_finished;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_ch
    sync_channel u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .retire_i  (retire_i[k]),
      .halt_i    (halt_i[k]),
      .release_i (w_release),
      .desync_i  (r_desync),
      .state_o   (w_state[k]),
      .clk_en_o  (clk_en_o[k])
    );
  end

  // Group status is decoded from registered channel states only.
  always_comb begin
    w_allParked = 1'b1;
    w_anyHold   = 1'b0;
    w_anyDone   = 1'b0;
    w_allDone   = 1'b1;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (w_state[k] == CH_RUN)  w_allParked = 1'b0;
      if (w_state[k] == CH_HOLD) w_anyHold   = 1'b1;
      if (w_state[k] == CH_DONE) w_anyDone   = 1'b1;
      else                       w_allDone   = 1'b0;
    end
  end

  assign w_release  = w_allParked & w_anyHold & ~w_anyDone & ~r_desync;
  assign w_mismatch = w_allParked & w_anyHold & w_anyDone;
  assign w_waitInc  = r_waitCnt + CNT_W'(1);
  // The stall fires as the count steps onto MAX_WAIT-1 with the group still open.
  assign w_timeout  = w_anyHold & ~w_release & (w_waitInc == WAIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_waitCnt   <= '0;
      r_retireCnt <= '0;
      r_desync    <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      if (!w_anyHold || w_release) begin
        r_waitCnt <= '0;
      end else if (r_waitCnt != WAIT_MAX) begin
        r_waitCnt <= w_waitInc;
      end
      if (w_release) begin
        r_retireCnt <= r_retireCnt + SYNC_CNT_W'(1);
      end
      if (w_mismatch || w_timeout) begin
        r_desync <= 1'b1;
      end
      if (w_allDone && !r_desync) begin
        r_finished <= 1'b1;
      end
    end
  end

  assign retire_o     = w_release;
  assign retire_cnt_o = r_retireCnt;
  assign desync_o     = r_desync;
  assign finished_o   = r_finished;

endmodule

// File: tb/tb_multi_clk_sync.sv
// Directed bench for multi_clk_sync: three instances (2 cores default wait,
// 2 cores with a short wait budget, 3 cores) driven from one cycle-stepped script.
module tb_multi_clk_sync;

  logic        clock;
  logic        reset;
  logic [1:0]  retA, haltA, retB, haltB;
  logic [2:0]  retC, haltC;
  logic [1:0]  clkEnA, clkEnB;
  logic [2:0]  clkEnC;
  logic        retOA, retOB, retOC;
  logic [31:0] cntA, cntB, cntC;
  logic        desA, desB, desC;
  logic        finA, finB, finC;

  int vectors = 0;
  int errors  = 0;

  multi_clk_sync #(.NUM_CORES(2)) u_a (
    .clk_i(clock), .rst_i(reset), .retire_i(retA), .halt_i(haltA),
    .clk_en_o(clkEnA), .retire_o(retOA), .retire_cnt_o(cntA),
    .desync_o(desA), .finished_o(finA)
  );

  multi_clk_sync #(.NUM_CORES(2), .MAX_WAIT(4)) u_b (
    .clk_i(clock), .rst_i(reset), .retire_i(retB), .halt_i(haltB),
    .clk_en_o(clkEnB), .retire_o(retOB), .retire_cnt_o(cntB),
    .desync_o(desB), .finished_o(finB)
  );

  multi_clk_sync #(.NUM_CORES(3)) u_c (
    .clk_i(clock), .rst_i(reset), .retire_i(retC), .halt_i(haltC),
    .clk_en_o(clkEnC), .retire_o(retOC), .retire_cnt_o(cntC),
    .desync_o(desC), .finished_o(finC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One call per clock cycle: drive just after the edge, leave time to settle.
  task automatic applyStimulus(input logic [1:0] rA, input logic [1:0] hA,
                               input logic [1:0] rB, input logic [2:0] hC);
    @(posedge clock);
    #1;
    retA  = rA;
    haltA = hA;
    retB  = rB;
    haltC = hC;
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    retA = '0; haltA = '0; retB = '0; haltB = '0; retC = '0; haltC = '0;
    #2;
    checkOutput("rst clkEnA", 32'(clkEnA), 32'h3);
    checkOutput("rst clkEnC", 32'(clkEnC), 32'h7);
    checkOutput("rst retOA",  32'(retOA),  32'h0);
    checkOutput("rst cntA",   cntA,        32'h0);
    checkOutput("rst desA",   32'(desA),   32'h0);
    checkOutput("rst finA",   32'(finA),   32'h0);

    @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);

    $display("[TB] aligned retire");
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("align clkEn t", 32'(clkEnA), 32'h0);
    checkOutput("align retO t",  32'(retOA),  32'h0);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("align retO t+1", 32'(retOA), 32'h1);
    checkOutput("align cnt t+1",  cntA,       32'h0);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("align clkEn t+2", 32'(clkEnA), 32'h3);
    checkOutput("align retO t+2",  32'(retOA),  32'h0);
    checkOutput("align cnt t+2",   cntA,        32'h1);
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);
    checkOutput("align cnt held", cntA, 32'h1);
    repeat (3) applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);

    $display("[TB] skewed retire");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 3'b000);
      checkOutput("skew clkEn0 low", 32'(clkEnA[0]), 32'h0);
      checkOutput("skew clkEn1 high", 32'(clkEnA[1]), 32'h1);
      checkOutput("skew no retO", 32'(retOA), 32'h0);
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("skew clkEn last", 32'(clkEnA), 32'h0);
    checkOutput("skew no retO last", 32'(retOA), 32'h0);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("skew retO", 32'(retOA), 32'h1);
    checkOutput("skew desync", 32'(desA), 32'h0);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("skew single pulse", 32'(retOA), 32'h0);
    checkOutput("skew cnt", cntA, 32'h2);
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);

    $display("[TB] timeout");
    applyStimulus(2'b00, 2'b00, 2'b01, 3'b000);
    checkOutput("tmo clkEn t", 32'(clkEnB), 32'h2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b01, 3'b000);
      checkOutput("tmo desync early", 32'(desB), 32'h0);
      checkOutput("tmo clkEn1 running", 32'(clkEnB[1]), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b01, 3'b000);
      checkOutput("tmo desync", 32'(desB), 32'h1);
      checkOutput("tmo clkEn off", 32'(clkEnB), 32'h0);
      checkOutput("tmo no retO", 32'(retOB), 32'h0);
    end
    checkOutput("tmo cnt", cntB, 32'h0);
    repeat (3) applyStimulus(2'b00, 2'b00, 2'b01, 3'b000);

    $display("[TB] finish");
    applyStimulus(2'b00, 2'b00, 2'b01, 3'b111);
    checkOutput("fin clkEn", 32'(clkEnC), 32'h0);
    checkOutput("fin t", 32'(finC), 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b01, 3'b111);
    checkOutput("fin t+1", 32'(finC), 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b01, 3'b111);
    checkOutput("fin t+2", 32'(finC), 32'h1);
    checkOutput("fin desync", 32'(desC), 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b01, 3'b111);
    checkOutput("fin sticky", 32'(finC), 32'h1);

    $display("[TB] mismatch");
    applyStimulus(2'b00, 2'b01, 2'b01, 3'b111);
    checkOutput("mis clkEn halt", 32'(clkEnA), 32'h2);
    applyStimulus(2'b10, 2'b01, 2'b01, 3'b111);
    checkOutput("mis clkEn retire", 32'(clkEnA), 32'h0);
    applyStimulus(2'b10, 2'b01, 2'b01, 3'b111);
    checkOutput("mis desync early", 32'(desA), 32'h0);
    checkOutput("mis no retO", 32'(retOA), 32'h0);
    applyStimulus(2'b10, 2'b01, 2'b01, 3'b111);
    checkOutput("mis desync", 32'(desA), 32'h1);
    checkOutput("mis finished", 32'(finA), 32'h0);
    checkOutput("mis no retO late", 32'(retOA), 32'h0);

    $display("[TB] reset mid-group");
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("rmg retO", 32'(retOA), 32'h1);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'b000);
    checkOutput("rmg hold clkEn", 32'(clkEnA), 32'h2);
    checkOutput("rmg cnt before", cntA, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rmg clkEn", 32'(clkEnA), 32'h3);
    checkOutput("rmg cnt", cntA, 32'h0);
    checkOutput("rmg retO", 32'(retOA), 32'h0);
    retA = 2'b00;

    $display("[TB] counter wrap");
    @(posedge clock);
    #1 reset = 1'b0;
    force u_a.r_retireCnt = 32'hFFFF_FFFF;
    #1 release u_a.r_retireCnt;
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("wrap retO", 32'(retOA), 32'h1);
    checkOutput("wrap cnt before", cntA, 32'hFFFF_FFFF);
    applyStimulus(2'b11, 2'b00, 2'b00, 3'b000);
    checkOutput("wrap cnt", cntA, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
